// File: rtl/output_pipe_ctrl_pkg.sv
// Shared state encoding and default field widths for the output_pipe layer sequencer.
package output_pipe_ctrl_pkg;

    localparam int OC_BEATS_W = 16;
    localparam int OC_PKTS_W  = 16;

    typedef enum logic [1:0] {
        OC_IDLE  = 2'd0,
        OC_RUN   = 2'd1,
        OC_DRAIN = 2'd2,
        OC_DONE  = 2'd3
    } oc_state_t;

endpackage

// File: rtl/output_pipe_ctrl_pkt_counter.sv
// Beat/packet counter pair: the beat count wraps on the last beat of a packet and
// bumps the packet count; the flags mark the last beat and the last packet.
module pkt_counter #(
    parameter int BEATS_W = 16,
    parameter int PKTS_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_adv,
    input  logic [BEATS_W-1:0] i_beats,
    input  logic [PKTS_W-1:0]  i_pkts,
    output logic               o_last_beat,
    output logic               o_last_pkt
);

    logic [BEATS_W-1:0] r_beat;
    logic [PKTS_W-1:0]  r_pkt;

    assign o_last_beat = (r_beat == i_beats - BEATS_W'(1));
    assign o_last_pkt  = (r_pkt == i_pkts - PKTS_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat <= '0;
            r_pkt  <= '0;
        end else if (i_clr) begin
            r_beat <= '0;
            r_pkt  <= '0;
        end else if (i_adv) begin
            if (o_last_beat) begin
                r_beat <= '0;
                r_pkt  <= r_pkt + PKTS_W'(1);
            end else begin
                r_beat <= r_beat + BEATS_W'(1);
            end
        end
    end

endmodule

// File: rtl/output_pipe_ctrl.sv
// Layer sequencer for output_pipe: mode bits, beat gating with tlast insertion, drain
// detection on M_AXIS. Optional drain watchdog enabled by OUTPUT_CTRL_TIMEOUT_EN.
module output_pipe_ctrl
    import output_pipe_ctrl_pkg::*;
#(
    parameter int BEATS_W        = OC_BEATS_W,
    parameter int PKTS_W         = OC_PKTS_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_is_maxpool,
    input  logic               cfg_is_3x3,
    input  logic [BEATS_W-1:0] cfg_beats,
    input  logic [PKTS_W-1:0]  cfg_in_pkts,
    input  logic [PKTS_W-1:0]  cfg_out_pkts,
    output logic               is_maxpool,
    output logic               is_3x3,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               pipe_tvalid,
    output logic               pipe_tlast,
    input  logic               pipe_tready,
    input  logic               m_tvalid,
    input  logic               m_tready,
    input  logic               m_tlast,
    output logic               busy,
    output logic               done,
    output logic               error
);

    oc_state_t          r_state, w_next;
    logic [BEATS_W-1:0] r_beats;
    logic [PKTS_W-1:0]  r_in_pkts, r_out_pkts, r_out_cnt;
    logic               r_is_maxpool, r_is_3x3;
    logic               w_accept, w_run, w_s_hs, w_m_last, w_out_full;
    logic               w_last_beat, w_last_pkt, w_timeout;

    assign w_accept   = (r_state == OC_IDLE) && cfg_valid;
    assign w_run      = (r_state == OC_RUN);
    assign w_s_hs     = w_run && s_valid && pipe_tready;
    assign w_m_last   = m_tvalid && m_tready && m_tlast;
    assign w_out_full = (r_out_cnt == r_out_pkts);

    assign is_maxpool = r_is_maxpool;
    assign is_3x3     = r_is_3x3;

    pkt_counter #(
        .BEATS_W (BEATS_W),
        .PKTS_W  (PKTS_W)
    ) u_in_cnt (
        .clk         (aclk),
        .rst_n       (aresetn),
        .i_clr       (w_accept),
        .i_adv       (w_s_hs),
        .i_beats     (r_beats),
        .i_pkts      (r_in_pkts),
        .o_last_beat (w_last_beat),
        .o_last_pkt  (w_last_pkt)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= OC_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pipe_tvalid = 1'b0;
        pipe_tlast  = 1'b0;
        s_ready     = 1'b0;
        unique case (r_state)
            OC_IDLE: begin
                cfg_ready = 1'b1;
                if (w_accept)
                    w_next = (cfg_beats == '0 || cfg_in_pkts == '0) ? OC_DONE : OC_RUN;
            end
            OC_RUN: begin
                busy        = 1'b1;
                pipe_tvalid = s_valid;
                s_ready     = pipe_tready;
                pipe_tlast  = w_last_beat;
                if (w_s_hs && w_last_beat && w_last_pkt) w_next = OC_DRAIN;
            end
            OC_DRAIN: begin
                busy = 1'b1;
                if (w_out_full || w_timeout) w_next = OC_DONE;
            end
            OC_DONE: begin
                done   = 1'b1;
                w_next = OC_IDLE;
            end
            default: w_next = OC_IDLE;
        endcase
    end

    // Output tlasts may arrive while input is still streaming, so count outside DRAIN too.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_beats      <= '0;
            r_in_pkts    <= '0;
            r_out_pkts   <= '0;
            r_out_cnt    <= '0;
            r_is_maxpool <= 1'b0;
            r_is_3x3     <= 1'b0;
        end else if (w_accept) begin
            r_beats      <= cfg_beats;
            r_in_pkts    <= cfg_in_pkts;
            r_out_pkts   <= cfg_out_pkts;
            r_out_cnt    <= '0;
            r_is_maxpool <= cfg_is_maxpool;
            r_is_3x3     <= cfg_is_3x3;
        end else if (r_state != OC_IDLE && w_m_last && !w_out_full) begin
            r_out_cnt <= r_out_cnt + PKTS_W'(1);
        end
    end

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("output_pipe_ctrl: TIMEOUT_CYCLES must be positive");
    end

`ifdef OUTPUT_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_error;
    logic            w_m_hs;

    assign w_m_hs    = m_tvalid && m_tready;
    // Normal completion wins over a coincident timeout.
    assign w_timeout = (r_state == OC_DRAIN) && !w_out_full && !w_m_hs &&
                       (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign error     = r_error;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state != OC_DRAIN || w_m_hs) r_wd <= '0;
            else                               r_wd <= r_wd + WD_W'(1);
            if (w_accept)       r_error <= 1'b0;
            else if (w_timeout) r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

endmodule

// File: doc/output_pipe_ctrl.md
# output_pipe_ctrl

Layer-level sequencer for `output_pipe`.
- Accepts one layer descriptor per handshake.
- Drives the pipe's static mode inputs (`is_maxpool`, `is_3x3`) and holds them constant for the whole layer.
- Gates the conv-core beat stream into the pipe and inserts `S_AXIS_tlast` at packet boundaries.
- Watches the pipe's output DMA stream to decide when the layer has fully drained, then pulses `done`.
- Sits between the layer scheduler (config side), the conv cores (beat side) and `output_pipe`.

## Interface

Parameters:
- `BEATS_W`, 16: width of the beats-per-packet field and the beat counter.
- `PKTS_W`, 16: width of the packet-count fields and the packet counters.
- `TIMEOUT_CYCLES`, 4096: drain watchdog limit. Used only with `OUTPUT_CTRL_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-low):
- `aclk`  in  1  clock
- `aresetn`  in  1  synchronous active-low reset
- `cfg_valid`  in  1  descriptor valid
- `cfg_ready`  out  1  controller can accept a descriptor
- `cfg_is_maxpool`  in  1  layer uses maxpool
- `cfg_is_3x3`  in  1  layer uses 3x3 kernels
- `cfg_beats`  in  BEATS_W  input beats per packet
- `cfg_in_pkts`  in  PKTS_W  input packets per layer
- `cfg_out_pkts`  in  PKTS_W  output packets the pipe will emit for this layer
- `is_maxpool`, `is_3x3`  out  1 each  registered mode bits to `output_pipe`
- `s_valid`  in  1  beat valid from conv cores
- `s_ready`  out  1  beat ready to conv cores
- `pipe_tvalid`, `pipe_tlast`  out  1 each  to `output_pipe` `S_AXIS`
- `pipe_tready`  in  1  from `output_pipe` `S_AXIS`
- `m_tvalid`, `m_tready`, `m_tlast`  in  1 each  monitor taps on `output_pipe` `M_AXIS`
- `busy`  out  1  high in RUN or DRAIN
- `done`  out  1  one-cycle layer-complete pulse
- `error`  out  1  sticky timeout flag; tied 0 without the macro

## Operation

States: IDLE, RUN, DRAIN, DONE.

- **IDLE**
  - `cfg_ready`=1.
  - On `cfg_valid`: latch all `cfg_*` fields, clear counters, load `is_maxpool`/`is_3x3`.
  - If `cfg_beats`==0 or `cfg_in_pkts`==0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Combinational pass-through: `pipe_tvalid` = `s_valid`; `s_ready` = `pipe_tready`.
  - Count accepted beats (`s_valid` & `pipe_tready`).
  - `pipe_tlast`=1 when the beat counter equals `cfg_beats`-1.
  - On the tlast beat, the beat counter wraps to 0 and the input packet counter increments.
  - When the tlast beat of the last packet is accepted, go to DRAIN.
- **DRAIN**
  - `pipe_tvalid`=0, `s_ready`=0.
  - When the output packet counter reaches `cfg_out_pkts`, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Output packet counter**
  - Counts `m_tvalid` & `m_tready` & `m_tlast` in every state except IDLE, including RUN, because output may overlap input.
  - Saturates at `cfg_out_pkts`.
  - If the count is already complete on DRAIN entry, DRAIN lasts exactly one cycle.
- **Outside RUN**: `pipe_tvalid`, `pipe_tlast` and `s_ready` are all 0.
- **Mode bits**: `is_maxpool`/`is_3x3` change only on a descriptor accept and never during RUN or DRAIN.

## Timing

- **Reset values**: state IDLE; `cfg_ready`=1 on the first cycle after reset; all other outputs 0; counters 0.
- **Reset mid-layer**: all state, counters and `error` clear on the next edge. No partial `done`.
- **Descriptor accept**: accepted at edge N gives RUN and updated mode bits from N+1. `cfg_ready` is 0 from N+1.
- **Data path**: zero latency; `s_ready` and `pipe_tvalid` are combinational from RUN state.
- **Layer end**:
  - Last input beat accepted at edge K gives DRAIN at K+1.
  - Final output tlast at edge M (M ≥ K+1) gives DONE during M+1 (`done`=1).
  - IDLE and `cfg_ready`=1 at M+2.
- **Back-to-back layers**: earliest next descriptor accept is at edge M+2.
- **Counters**: wrap cleanly only at the packet boundary. No overflow, because `cfg_*` values fit their widths.

## Configuration

`OUTPUT_CTRL_TIMEOUT_EN`:
- **Defined**:
  - A watchdog counts DRAIN cycles since the last `M_AXIS` handshake.
  - On reaching `TIMEOUT_CYCLES`: set sticky `error`, go to DONE (`done` pulses).
  - `error` clears on reset or on the next descriptor accept.
- **Undefined**: no watchdog logic; `error` is constant 0; DRAIN waits indefinitely.

## Structure

- Shared package (`system_parameters` header):
  - State encoding constants `OC_IDLE`, `OC_RUN`, `OC_DRAIN`, `OC_DONE`.
  - Default `BEATS_W`/`PKTS_W`.
- One natural sub-module, `pkt_counter`: a beat/packet counter pair with last-beat and last-packet flags. Instantiate it for the input side; the output counter stays inline.

## Test plan

1. **Basic layer**: cfg beats=8, in_pkts=4, out_pkts=4, `M_AXIS_tready`=1.
   - 32 beats pass through.
   - `pipe_tlast` on beats 7, 15, 23, 31.
   - `done` 1 cycle after the 4th output tlast.
2. **Backpressure**: `pipe_tready` toggled randomly.
   - Beat and tlast positions are unchanged.
   - `s_ready` mirrors `pipe_tready` only in RUN.
3. **Mode hold**: cfg maxpool=1, 3x3=1, then a second descriptor is offered mid-RUN.
   - `cfg_ready`=0 and mode bits are unchanged until IDLE.
4. **Zero-size descriptor**: cfg in_pkts=0.
   - DONE on the next cycle.
   - No `pipe_tvalid` ever.
5. **Reset mid-RUN**: `aresetn` low after beat 5 of packet 2.
   - All outputs 0 next cycle.
   - A fresh layer runs correctly afterwards.
6. **Watchdog** (with macro): out_pkts=5 but the pipe emits 4.
   - `error`=1 and `done` pulse exactly `TIMEOUT_CYCLES` after the last output handshake.
